csync_decoder: RTL

Recovers separate horizontal and vertical sync from the gate array's composite sync. The composite is XNOR-style: active-low `SYNC_N`, inverted for the duration of VSYNC. The block sits on the video-output side, downstream of the sync/interrupt generator. It feeds the scaler and OSD with clean `HSYNC_O`/`VSYNC_O`, a measured HSYNC width and a lines-per-frame count. All timing is measured in CCLK ticks (1 MHz enable) inside the single system clock domain.

---
 rtl/ga_video_pkg.sv | 18 +
 rtl/csync_decoder_if.sv | 31 +++
 rtl/pulse_timer.sv | 39 +++
 rtl/csync_decoder.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ga_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ga_video_pkg
// Brief    : Shared types and constants for the gate-array video output path.
// Revision : 1.0
// ============================================================================
package ga_video_pkg;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    VSYNC  = 1'b1
  } csync_state_t;

  localparam int HS_MAX_DEF = 8;
  localparam int HSW_W      = 5;

endpackage
`default_nettype wire

// File: rtl/csync_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : csync_decoder_if
// Brief    : Composite-sync input and recovered sync/measurement outputs.
// Revision : 1.0
// ============================================================================
interface csync_decoder_if #(
  parameter int LCNT_W = 9
) ();
  import ga_video_pkg::*;

  logic              cclk_en;
  logic              SYNC_N;
  logic              HSYNC_O;
  logic              VSYNC_O;
  logic [HSW_W-1:0]  HSW_O;
  logic [LCNT_W-1:0] FRAME_LINES_O;
  logic              LOCKED_O;

  modport master (
    output cclk_en, SYNC_N,
    input  HSYNC_O, VSYNC_O, HSW_O, FRAME_LINES_O, LOCKED_O
  );

  modport slave (
    input  cclk_en, SYNC_N,
    output HSYNC_O, VSYNC_O, HSW_O, FRAME_LINES_O, LOCKED_O
  );

endinterface
`default_nettype wire

// File: rtl/pulse_timer.sv
`default_nettype none
// ============================================================================
// Module   : pulse_timer
// Brief    : Saturating tick counter, cleared on edge, with limit comparator.
// Revision : 1.0
// ============================================================================
module pulse_timer #(
  parameter int W     = 5,
  parameter int LIMIT = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         i_clr,
  input  wire logic         i_en,
  output logic [W-1:0]      o_cnt,
  output logic              o_at_limit
);

  localparam logic [W-1:0] c_limit = W'(LIMIT);
  localparam logic [W-1:0] c_max   = '1;

  logic [W-1:0] r_cnt;

  // Clear has priority so an edge coinciding with a tick is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_at_limit = (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/csync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : csync_decoder
// Brief    : Splits XNOR composite sync into HSYNC/VSYNC, measures HSYNC
//            width and lines per frame.
// Revision : 1.0
// ============================================================================
module csync_decoder
  import ga_video_pkg::*;
#(
  parameter int HS_MAX = HS_MAX_DEF,
  parameter int LCNT_W = 9
) (
  input  wire logic       clk,
  input  wire logic       reset,
  csync_decoder_if.slave  bus
);

  localparam logic [LCNT_W-1:0] c_lcnt_max = '1;

  csync_state_t      r_state, w_state_nx;
  logic              r_sync_d;
  logic              r_hsync, w_hsync_nx;
  logic              r_vsync, w_vsync_nx;
  logic [HSW_W-1:0]  r_hsw, w_hsw_nx;
  logic [LCNT_W-1:0] r_frame, w_frame_nx;
  logic [LCNT_W-1:0] r_lcnt, w_lcnt_nx;
  logic [1:0]        r_vs_seen, w_vs_seen_nx;

  logic              w_fall, w_rise;
  logic [HSW_W-1:0]  w_pcnt;
  logic              w_at_limit;

  assign w_fall = r_sync_d & ~bus.SYNC_N;
  assign w_rise = ~r_sync_d & bus.SYNC_N;

  pulse_timer #(
    .W     (HSW_W),
    .LIMIT (HS_MAX)
  ) u_pulse_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_fall | w_rise),
    .i_en       (bus.cclk_en),
    .o_cnt      (w_pcnt),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= NORMAL;
      r_sync_d  <= 1'b1;
      r_hsync   <= 1'b0;
      r_vsync   <= 1'b0;
      r_hsw     <= '0;
      r_frame   <= '0;
      r_lcnt    <= '0;
      r_vs_seen <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_sync_d  <= bus.SYNC_N;
      r_hsync   <= w_hsync_nx;
      r_vsync   <= w_vsync_nx;
      r_hsw     <= w_hsw_nx;
      r_frame   <= w_frame_nx;
      r_lcnt    <= w_lcnt_nx;
      r_vs_seen <= w_vs_seen_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_hsync_nx   = r_hsync;
    w_vsync_nx   = r_vsync;
    w_hsw_nx     = r_hsw;
    w_frame_nx   = r_frame;
    w_lcnt_nx    = r_lcnt;
    w_vs_seen_nx = r_vs_seen;

    case (r_state)
      NORMAL: begin
        if (w_fall) begin
          w_hsync_nx = 1'b1;
        end else if (w_rise) begin
          w_hsync_nx = 1'b0;
          w_hsw_nx   = w_pcnt;
        end else if (bus.cclk_en && !bus.SYNC_N && w_at_limit) begin
          // Overlong low: the pulse was really the start of VSYNC.
          w_state_nx = VSYNC;
          w_hsync_nx = 1'b0;
          w_vsync_nx = 1'b1;
          w_frame_nx = r_lcnt;
          w_lcnt_nx  = '0;
          if (r_vs_seen != 2'd3) begin
            w_vs_seen_nx = r_vs_seen + 2'd1;
          end
        end
      end
      VSYNC: begin
        if (w_rise) begin
          w_hsync_nx = 1'b1;
        end else if (w_fall) begin
          w_hsync_nx = 1'b0;
          w_hsw_nx   = w_pcnt;
        end else if (bus.cclk_en && bus.SYNC_N && w_at_limit) begin
          w_state_nx = NORMAL;
          w_hsync_nx = 1'b0;
          w_vsync_nx = 1'b0;
        end
      end
      default: w_state_nx = NORMAL;
    endcase

    if (w_hsync_nx && !r_hsync && (r_lcnt != c_lcnt_max)) begin
      w_lcnt_nx = r_lcnt + 1'b1;
    end
  end

  assign bus.HSYNC_O       = r_hsync;
  assign bus.VSYNC_O       = r_vsync;
  assign bus.HSW_O         = r_hsw;
  assign bus.FRAME_LINES_O = r_frame;
  assign bus.LOCKED_O      = r_vs_seen[1];

endmodule
`default_nettype wire
